memory_stage: RTL

Memory stage of the 16-bit five-stage pipeline, placed directly after the execute stage. It consumes the execute result as a data-memory address or passes it through. It owns the data memory and the stack pointer, and it performs load, store, push and pop accesses. Two-word PC save/restore for CALL/RET/RTI uses a two-cycle state machine that stalls upstream. All results are registered toward the write-back stage.

---
 rtl/memory_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage
// Memory stage of the 16-bit five-stage pipeline. Owns the data memory and
// the stack pointer, and performs LDD/STD, single-word PUSH/POP and the
// two-word PC save/restore used by CALL/RET/RTI. All results toward
// write-back are registered.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           asynchronous reset, active low
//   valid_in      an instruction is presented this cycle
//   mem_read      LDD at aluResult[ADDR_WIDTH-1:0]
//   mem_write     STD at aluResult[ADDR_WIDTH-1:0]
//   push, pop     stack access
//   two_word      push/pop moves a 32-bit PC (CALL/RET)
//   aluResult     address or pass-through value
//   storeData     data for STD or single-word PUSH
//   pcIn          PC for a two-word push
//   rdIn          destination register
//   regWriteIn    write-back enable
//   stall         combinational; upstream holds all inputs while high
//   valid_out     registered result valid
//   readData      loaded or popped word
//   aluResultOut  registered aluResult
//   rdOut         registered rdIn
//   regWriteOut   registered regWriteIn, forced low on bubble or error
//   pcOut         restored PC
//   pcValid       one-cycle pulse when pcOut is valid
//   opErr         one-cycle pulse on an illegal control combination
module memory_stage #(
    parameter int unsigned              ADDR_WIDTH = 11,
    parameter logic [ADDR_WIDTH-1:0]    SP_RESET   = '1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        push,
    input  logic        pop,
    input  logic        two_word,
    input  logic [15:0] aluResult,
    input  logic [15:0] storeData,
    input  logic [31:0] pcIn,
    input  logic [2:0]  rdIn,
    input  logic        regWriteIn,
    output logic        stall,
    output logic        valid_out,
    output logic [15:0] readData,
    output logic [15:0] aluResultOut,
    output logic [2:0]  rdOut,
    output logic        regWriteOut,
    output logic [31:0] pcOut,
    output logic        pcValid,
    output logic        opErr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_LO = 2'd1,
        ST_POP_HI  = 2'd2
    } state_t;

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [15:0]           mem_r [0:DEPTH-1];
    state_t                state_r;
    logic [ADDR_WIDTH-1:0] sp_r;
    logic [15:0]           pc_lo_r;

    logic [ADDR_WIDTH-1:0] sp_inc_s;
    logic [ADDR_WIDTH-1:0] sp_dec_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [2:0]            op_count_s;
    logic                  illegal_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [15:0]           mem_wdata_s;

    // SP arithmetic wraps naturally at ADDR_WIDTH bits
    assign sp_inc_s   = sp_r + 1'b1;
    assign sp_dec_s   = sp_r - 1'b1;
    assign mem_addr_s = aluResult[ADDR_WIDTH-1:0];

    // More than one access kind, or two_word without a stack access, is illegal
    assign op_count_s = {2'b00, mem_read} + {2'b00, mem_write} + {2'b00, push} + {2'b00, pop};
    assign illegal_s  = (op_count_s > 3'd1) || (two_word && !(push || pop));

    // Stall decode and memory write port selection
    always_comb begin
        stall       = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = sp_r;
        mem_wdata_s = storeData;
        case (state_r)
            ST_IDLE: begin
                if (valid_in && !illegal_s) begin
                    if (two_word) begin
                        // First half happens now; hold upstream for the second half
                        stall = 1'b1;
                        if (push) begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = pcIn[31:16];
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else if (mem_write) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = mem_addr_s;
                    end else if (push) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_PUSH_LO: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = pcIn[15:0];
            end
            ST_POP_HI: begin
                mem_we_s = 1'b0;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Data memory write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Stack pointer, two-word state machine and registered write-back outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            sp_r         <= SP_RESET;
            pc_lo_r      <= 16'h0000;
            valid_out    <= 1'b0;
            readData     <= 16'h0000;
            aluResultOut <= 16'h0000;
            rdOut        <= 3'd0;
            regWriteOut  <= 1'b0;
            pcOut        <= 32'h0000_0000;
            pcValid      <= 1'b0;
            opErr        <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            regWriteOut <= 1'b0;
            pcValid     <= 1'b0;
            opErr       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (illegal_s) begin
                            valid_out    <= 1'b1;
                            opErr        <= 1'b1;
                            aluResultOut <= aluResult;
                            rdOut        <= rdIn;
                        end else if (two_word) begin
                            if (push) begin
                                sp_r    <= sp_dec_s;
                                state_r <= ST_PUSH_LO;
                            end else begin
                                // POP with two_word: low word sits just above SP
                                pc_lo_r <= mem_r[sp_inc_s];
                                sp_r    <= sp_inc_s;
                                state_r <= ST_POP_HI;
                            end
                        end else begin
                            valid_out    <= 1'b1;
                            aluResultOut <= aluResult;
                            rdOut        <= rdIn;
                            regWriteOut  <= regWriteIn;
                            if (mem_read) begin
                                readData <= mem_r[mem_addr_s];
                            end else if (push) begin
                                sp_r <= sp_dec_s;
                            end else if (pop) begin
                                readData <= mem_r[sp_inc_s];
                                sp_r     <= sp_inc_s;
                            end else begin
                                sp_r <= sp_r;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PUSH_LO: begin
                    sp_r         <= sp_dec_s;
                    valid_out    <= 1'b1;
                    aluResultOut <= aluResult;
                    rdOut        <= rdIn;
                    regWriteOut  <= regWriteIn;
                    state_r      <= ST_IDLE;
                end
                ST_POP_HI: begin
                    sp_r         <= sp_inc_s;
                    pcOut        <= {mem_r[sp_inc_s], pc_lo_r};
                    pcValid      <= 1'b1;
                    valid_out    <= 1'b1;
                    aluResultOut <= aluResult;
                    rdOut        <= rdIn;
                    regWriteOut  <= regWriteIn;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
